// File: rtl/dsram_like_responder.sv
// SRAM-like data-memory responder: byte-strobed reads/writes with an in-order
// response FIFO, each entry held back RESP_DELAY cycles before it may answer.
module dsram_like_responder #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 4,
  parameter int RESP_DELAY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     wr,
  input  logic [1:0]               size,
  input  logic [3:0]               wstrb,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic                     stall_addr,
  output logic                     addr_ok,
  output logic                     data_ok,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (RESP_DELAY < 1) ? 1 : $clog2(RESP_DELAY + 1);
  localparam int WORDS = 1 << ADDR_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESP_DELAY);

  logic [31:0]       mem      [WORDS];
  logic [31:0]       ent_data [DEPTH];
  logic [CNT_W-1:0]  ent_cnt  [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] widx;
  logic              push;
  logic              pop;

  // size and the bits outside the word index never influence behaviour
  logic unused_bits;
  assign unused_bits = &{1'b0, size, addr[31:ADDR_W+2], addr[1:0]};

  assign widx    = addr[ADDR_W+1:2];
  assign addr_ok = req && !stall_addr && (outstanding != FULL_CNT);
  assign push    = addr_ok;

  // An entry is live when its distance from the head is below the occupancy
  always_comb begin
    ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ({1'b0, PTR_W'(i) - rd_ptr} < outstanding);
    end
  end

  assign pop = ent_vld[rd_ptr] && (ent_cnt[rd_ptr] == '0);

  // Control: pointers, occupancy and the registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      data_ok     <= 1'b0;
      rdata       <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      data_ok <= pop;
      rdata   <= pop ? ent_data[rd_ptr] : '0;
    end
  end

  // Datapath: memory array and FIFO payload/countdowns carry no reset
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_cnt[i] != '0)) begin
        ent_cnt[i] <= ent_cnt[i] - 1'b1;
      end
    end
    if (push) begin
      ent_data[wr_ptr] <= wr ? 32'd0 : mem[widx];
      ent_cnt[wr_ptr]  <= CNT_INIT;
    end
  end

endmodule
